pll_lock_sequencer: RTL and testbench
=====================================

Name: pll_lock_sequencer

Overview:
- Controller for the 3-output 143 MHz system PLL, running in the 50 MHz reference-clock domain.
- Sequences the PLL reset, waits for lock with a timeout and retries, and qualifies lock over a stability window before releasing the downstream system reset.
- On loss of lock it reasserts the system reset and restarts the sequence. Diagnostic status goes to the control/status register block.

Parameters:
- RST_CYCLES, 16, cycles pll_rst is held high per attempt (>=1).
- LOCK_TIMEOUT, 50000, cycles allowed in WAIT_LOCK before a retry (1 ms at 50 MHz).
- STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before release.
- MAX_RETRIES, 7, number of timeouts tolerated before FAIL (<=15).
- CNT_W, 16, width of the shared cycle counter (must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)).

Ports:
- clk  in  1  50 MHz reference clock, same source as the PLL refclk.
- reset_n  in  1  asynchronous, active-low reset.
- pll_locked  in  1  PLL locked output; asynchronous to clk.
- pll_rst  out  1  PLL reset, active-high.
- sys_reset_n  out  1  downstream reset, active-low; high only in RUN.
- relock_req  in  1  single-cycle software request to restart the sequence.
- clr_sticky  in  1  single-cycle clear of lock_lost.
- state  out  3  0=PLL_RST 1=WAIT_LOCK 2=STABLE 3=RUN 4=FAIL.
- retry_cnt  out  4  timeouts since reset or last relock_req.
- fail  out  1  high in FAIL.
- lock_lost  out  1  sticky: lock dropped while in RUN.

Behaviour:
- Reset values:
  - pll_rst=1, sys_reset_n=0, state=PLL_RST.
  - retry_cnt=0, fail=0, lock_lost=0.
  - Counter cnt=0; both synchronizer flops 0.
- pll_locked passes through a 2-flop synchronizer giving locked_s, which has 2 cycles of latency. The FSM uses only locked_s.
- All outputs are registered and change on the same edge as the state transition they belong to.
- PLL_RST:
  - pll_rst=1, sys_reset_n=0, cnt increments.
  - At cnt==RST_CYCLES-1: go to WAIT_LOCK, cnt=0, pll_rst=0.
- WAIT_LOCK:
  - cnt increments.
  - If locked_s=1: go to STABLE, cnt=0.
  - Else at cnt==LOCK_TIMEOUT-1: if retry_cnt==MAX_RETRIES go to FAIL; otherwise retry_cnt+1, go to PLL_RST, cnt=0.
  - When locked_s rises on the same cycle as the timeout, lock wins.
- STABLE:
  - cnt increments while locked_s=1.
  - If locked_s=0: go back to WAIT_LOCK with cnt=0, a fresh timeout and no retry increment.
  - At cnt==STABLE_CYCLES-1 with locked_s=1: go to RUN, sys_reset_n=1.
- RUN:
  - If locked_s=0: sys_reset_n=0, lock_lost=1, go to PLL_RST, cnt=0, retry_cnt unchanged.
- FAIL:
  - pll_rst=1, sys_reset_n=0, fail=1.
  - Stays in FAIL until relock_req.
- relock_req has highest priority in every state. It forces PLL_RST, cnt=0, retry_cnt=0, fail=0 and sys_reset_n=0 on the next edge. A request arriving in PLL_RST restarts the count.
- clr_sticky clears lock_lost. If it coincides with a lock-loss event, set wins.
- retry_cnt saturates at MAX_RETRIES and never wraps.
- Asserting reset_n mid-sequence returns everything to the reset values immediately (asynchronous).
- Mid-sequence loss of lock in PLL_RST or WAIT_LOCK is ignored.
- A lock pulse shorter than 1 cycle may be missed; this is acceptable.

Test Plan (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2):
- Nominal lock:
  - Stimulus: release reset_n; raise pll_locked 5 cycles after pll_rst falls.
  - Required response: pll_rst high exactly 4 cycles; STABLE entered 2 cycles after pll_locked rises; sys_reset_n rises 8 cycles later; retry_cnt=0.
- Timeout to FAIL:
  - Stimulus: hold pll_locked=0.
  - Required response: pll_rst pulses 3 times (4 cycles each, separated by 20-cycle waits); retry_cnt goes 1 then 2; FAIL after the 3rd timeout with fail=1 and pll_rst=1.
  - Then pulse relock_req: retry_cnt=0, fail=0, state=PLL_RST.
- Glitch during STABLE:
  - Stimulus: drop pll_locked for 3 cycles at STABLE cnt=5.
  - Required response: return to WAIT_LOCK; retry_cnt unchanged; full 8-cycle window required again before sys_reset_n=1.
- Loss in RUN:
  - Stimulus: drop pll_locked while in RUN.
  - Required response: 2 cycles later sys_reset_n=0, lock_lost=1, state=PLL_RST.
  - clr_sticky then clears lock_lost. clr_sticky asserted on the same cycle as a second loss leaves lock_lost=1.
- Priority:
  - Stimulus: relock_req on the same cycle as the WAIT_LOCK timeout at retry_cnt=2.
  - Required response: PLL_RST with retry_cnt=0; FAIL is not entered.
- Async reset mid-RUN:
  - Stimulus: assert reset_n low in RUN.
  - Required response: sys_reset_n=0 and pll_rst=1 immediately, without waiting for a clk edge; lock_lost=0.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
`timescale 1ns/1ps
// PLL bring-up controller: pulses the PLL reset, waits for lock with timeout/retry,
// qualifies lock over a stability window, then releases the downstream system reset.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// PLL_RST    | pll_rst held high for RST_CYCLES
// WAIT_LOCK  | waiting for synchronized lock, LOCK_TIMEOUT cycles max
// STABLE     | lock must hold for STABLE_CYCLES consecutive cycles
// RUN        | system reset released; lock monitored
// FAIL       | retries exhausted; parked until relock_req
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 7,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_reset_n,
  input  logic       relock_req,
  input  logic       clr_sticky,
  output logic [2:0] state,
  output logic [3:0] retry_cnt,
  output logic       fail,
  output logic       lock_lost
);

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRIES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_reset_n_q, sys_reset_n_d;
  logic             fail_q, fail_d;
  logic             lock_lost_q, lock_lost_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             locked_s;
  logic             lock_loss;

  assign locked_s = sync2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_PLL_RST;
      cnt_q         <= '0;
      retry_q       <= '0;
      pll_rst_q     <= 1'b1;
      sys_reset_n_q <= 1'b0;
      fail_q        <= 1'b0;
      lock_lost_q   <= 1'b0;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      pll_rst_q     <= pll_rst_d;
      sys_reset_n_q <= sys_reset_n_d;
      fail_q        <= fail_d;
      lock_lost_q   <= lock_lost_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
    end
  end

  always_comb begin
    sync1_d       = pll_locked;
    sync2_d       = sync1_q;
    state_d       = state_q;
    cnt_d         = cnt_q;
    retry_d       = retry_q;
    pll_rst_d     = pll_rst_q;
    sys_reset_n_d = sys_reset_n_q;
    fail_d        = fail_q;
    // A loss event in RUN beats a simultaneous clear of the sticky flag.
    lock_loss     = (state_q == ST_RUN) && !locked_s;
    lock_lost_d   = lock_loss | (lock_lost_q & ~clr_sticky);

    if (relock_req) begin
      state_d       = ST_PLL_RST;
      cnt_d         = '0;
      retry_d       = '0;
      pll_rst_d     = 1'b1;
      sys_reset_n_d = 1'b0;
      fail_d        = 1'b0;
    end else begin
      unique case (state_q)
        ST_PLL_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d   = ST_WAIT_LOCK;
            cnt_d     = '0;
            pll_rst_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d     = '0;
            pll_rst_d = 1'b1;
            if (retry_q >= RETRY_MAX) begin
              state_d = ST_FAIL;
              fail_d  = 1'b1;
            end else begin
              state_d = ST_PLL_RST;
              retry_d = retry_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_STABLE: begin
          if (!locked_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d       = ST_RUN;
            cnt_d         = '0;
            sys_reset_n_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!locked_s) begin
            state_d       = ST_PLL_RST;
            cnt_d         = '0;
            pll_rst_d     = 1'b1;
            sys_reset_n_d = 1'b0;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d       = ST_PLL_RST;
          cnt_d         = '0;
          pll_rst_d     = 1'b1;
          sys_reset_n_d = 1'b0;
          fail_d        = 1'b0;
        end
      endcase
    end
  end

  assign pll_rst     = pll_rst_q;
  assign sys_reset_n = sys_reset_n_q;
  assign state       = state_q;
  assign retry_cnt   = retry_q;
  assign fail        = fail_q;
  assign lock_lost   = lock_lost_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for pll_lock_sequencer: a timestamp-based reference model pushes
// the expected outputs for each edge; a monitor pops and compares after every edge.
module tb_pll_lock_sequencer;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRIES   = 2;

  localparam int P_RST = 0, P_WAIT = 1, P_STABLE = 2, P_RUN = 3, P_FAIL = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       clr_sticky = 1'b0;
  logic       pll_rst, sys_reset_n, fail, lock_lost;
  logic [2:0] state;
  logic [3:0] retry_cnt;

  always #5 clk = ~clk;

  pll_lock_sequencer #(
    .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT), .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRIES(MAX_RETRIES), .CNT_W(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .pll_rst(pll_rst),
    .sys_reset_n(sys_reset_n), .relock_req(relock_req), .clr_sticky(clr_sticky),
    .state(state), .retry_cnt(retry_cnt), .fail(fail), .lock_lost(lock_lost)
  );

  typedef struct {
    logic [2:0] st;
    logic [3:0] rc;
    logic       prst;
    logic       srn;
    logic       fl;
    logic       ll;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: phase plus the edge index at which it was entered; elapsed
  // time in a phase is plain subtraction of edge indices.
  int m_e, m_r, m_t, m_phase, m_retries;
  bit m_lost;
  bit hist[0:65535];

  function automatic bit m_ls(int edge_i);
    return (edge_i - 2 > m_r) ? hist[edge_i - 2] : 1'b0;
  endfunction

  function automatic exp_t m_expect();
    exp_t x;
    x.st   = 3'(m_phase);
    x.rc   = 4'(m_retries);
    x.prst = (m_phase == P_RST) || (m_phase == P_FAIL);
    x.srn  = (m_phase == P_RUN);
    x.fl   = (m_phase == P_FAIL);
    x.ll   = m_lost;
    return x;
  endfunction

  task automatic m_reset();
    m_r = m_e; m_t = m_e; m_phase = P_RST; m_retries = 0; m_lost = 1'b0;
  endtask

  task automatic m_step(bit lk, bit rr, bit cs);
    int  n;
    bit  ls, loss;
    m_e = m_e + 1;
    hist[m_e] = lk;
    ls   = m_ls(m_e);
    n    = m_e - 1 - m_t;
    loss = (m_phase == P_RUN) && !ls;
    if (rr) begin
      m_phase = P_RST; m_t = m_e; m_retries = 0;
    end else if (m_phase == P_RST && n == RST_CYCLES - 1) begin
      m_phase = P_WAIT; m_t = m_e;
    end else if (m_phase == P_WAIT && ls) begin
      m_phase = P_STABLE; m_t = m_e;
    end else if (m_phase == P_WAIT && n == LOCK_TIMEOUT - 1) begin
      m_t = m_e;
      if (m_retries == MAX_RETRIES) m_phase = P_FAIL;
      else begin m_retries++; m_phase = P_RST; end
    end else if (m_phase == P_STABLE && !ls) begin
      m_phase = P_WAIT; m_t = m_e;
    end else if (m_phase == P_STABLE && n == STABLE_CYCLES - 1) begin
      m_phase = P_RUN; m_t = m_e;
    end else if (loss) begin
      m_phase = P_RST; m_t = m_e;
    end
    if (loss) m_lost = 1'b1;
    else if (cs) m_lost = 1'b0;
  endtask

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at posedge+2, push the expectation for the next edge.
  task automatic cycle(bit lk, bit rr, bit cs);
    pll_locked = lk; relock_req = rr; clr_sticky = cs;
    if (reset_n) m_step(lk, rr, cs);
    sb_q.push_back(m_expect());
    @(posedge clk); #2;
  endtask

  task automatic run_until(int phase, bit lk, int limit, string name);
    int n = 0;
    while (m_phase != phase && n < limit) begin cycle(lk, 1'b0, 1'b0); n++; end
    if (m_phase != phase) begin
      checks++; errors++;
      $display("FAIL %s bound expired: phase=%0d required=%0d", name, m_phase, phase);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk); #1;
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        chk("state",       8'(state),       8'(x.st));
        chk("retry_cnt",   8'(retry_cnt),   8'(x.rc));
        chk("pll_rst",     8'(pll_rst),     8'(x.prst));
        chk("sys_reset_n", 8'(sys_reset_n), 8'(x.srn));
        chk("fail",        8'(fail),        8'(x.fl));
        chk("lock_lost",   8'(lock_lost),   8'(x.ll));
      end
    end
  end

  initial begin : driver
    int hold;
    bit lk;
    bit cs;
    m_e = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #2;
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    reset_n = 1'b1;
    m_reset();

    // Nominal lock: pll_locked rises 5 cycles after pll_rst falls.
    run_until(P_WAIT, 0, 50, "nominal_rst");
    repeat (4) cycle(0, 0, 0);
    run_until(P_RUN, 1, 60, "nominal_run");
    repeat (4) cycle(1, 0, 0);

    // Loss in RUN, clear of sticky flag, then clear coinciding with a second loss.
    repeat (3) cycle(0, 0, 0);
    repeat (3) cycle(0, 0, 0);
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    run_until(P_RUN, 1, 80, "relock_run");
    repeat (3) cycle(1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cs = (m_phase == P_RUN) && !m_ls(m_e + 1);
      cycle(0, 0, cs);
    end

    // Glitch in STABLE at cnt=5.
    run_until(P_STABLE, 1, 80, "glitch_stable");
    while (m_phase == P_STABLE && (m_e - m_t) < 5) cycle(1, 0, 0);
    repeat (3) cycle(0, 0, 0);
    run_until(P_RUN, 1, 80, "glitch_run");
    repeat (2) cycle(1, 0, 0);

    // Timeouts to FAIL, then relock_req.
    run_until(P_FAIL, 0, 300, "to_fail");
    repeat (3) cycle(0, 0, 0);
    cycle(0, 1, 0);
    repeat (3) cycle(0, 0, 0);

    // relock_req on the final timeout edge at retry_cnt=2.
    hold = 0;
    while (!(m_phase == P_WAIT && m_retries == MAX_RETRIES && (m_e - m_t) == LOCK_TIMEOUT - 1)
           && hold < 300) begin
      cycle(0, 0, 0); hold++;
    end
    cycle(0, 1, 0);
    repeat (6) cycle(0, 0, 0);

    // Asynchronous reset while in RUN.
    run_until(P_RUN, 1, 80, "pre_async");
    repeat (2) cycle(1, 0, 0);
    reset_n = 1'b0;
    #1;
    chk("async_sys_reset_n", 8'(sys_reset_n), 8'd0);
    chk("async_pll_rst",     8'(pll_rst),     8'd1);
    chk("async_lock_lost",   8'(lock_lost),   8'd0);
    chk("async_state",       8'(state),       8'd0);
    m_reset();
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    reset_n = 1'b1;
    m_reset();

    // Randomized runs of lock/unlock with occasional relock and clear requests.
    hold = 0;
    lk = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        lk   = ($urandom_range(0, 2) != 0);
        hold = lk ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 30));
      end
      hold--;
      cycle(lk, ($urandom_range(0, 199) == 0), ($urandom_range(0, 24) == 0));
    end

    @(posedge clk); #3;
    if (sb_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
